// File: rtl/router_xbar_scheduler.sv
// Crossbar scheduler for the 4-port router: each batch moves input-buffer packets
// to free output buffers, using one round-robin pointer per output.
// Optional feature macro: ROUTER_SCHED_STATS_EN adds per-input grant counters
// (stats_clr / grant_cnt ports).
module router_xbar_scheduler #(
  parameter int unsigned DEST_LSB = 28,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sched_en,
  input  logic [3:0]            data_available,
  input  logic [3:0]            data_empty,
  input  logic [3:0][31:0]      pkt_in,
  output logic [3:0]            clear_data_available,
  output logic [3:0]            wr_data,
  output logic [3:0][1:0]       select_out,
  output logic                  busy
`ifdef ROUTER_SCHED_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [3:0][CNT_W-1:0] grant_cnt
`endif
);

  localparam int unsigned NPORT = 4;

  typedef enum logic {ARB = 1'b0, ISSUE = 1'b1} state_t;

  state_t          state, state_d;
  logic [3:0][1:0] ptr, ptr_d;
  logic [3:0]      req [NPORT];
  logic [3:0]      gnt_wr, gnt_clr;
  logic [3:0][1:0] gnt_sel;
  logic [3:0]      wr_d, clr_d;
  logic [3:0][1:0] sel_d;
  logic            busy_d;
  logic            found;
  logic [1:0]      idx;
  logic            unused_pkt_bits;

  // Only the destination field of each packet matters here.
  assign unused_pkt_bits = ^pkt_in;

  // Request matrix: req[o][i] = input i holds a packet for output o.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      req[o] = '0;
      for (int i = 0; i < NPORT; i++) begin
        req[o][i] = data_available[i] && (pkt_in[i][DEST_LSB +: 2] == 2'(o));
      end
    end
  end

  // Per-output round-robin search starting at ptr[o]; full outputs grant nothing.
  always_comb begin
    gnt_wr  = '0;
    gnt_clr = '0;
    gnt_sel = '0;
    found   = 1'b0;
    idx     = '0;
    for (int o = 0; o < NPORT; o++) begin
      found = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
        idx = ptr[o] + 2'(k);
        if (data_empty[o] && !found && req[o][idx]) begin
          found      = 1'b1;
          gnt_wr[o]  = 1'b1;
          gnt_clr[idx] = 1'b1;
          gnt_sel[o] = idx;
        end
      end
    end
  end

  // Next-state and next-output logic: grants are captured in ARB, shown in ISSUE.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    wr_d    = '0;
    clr_d   = '0;
    sel_d   = '0;
    busy_d  = 1'b0;
    case (state)
      ARB: begin
        if (sched_en && (|gnt_wr)) begin
          state_d = ISSUE;
          wr_d    = gnt_wr;
          clr_d   = gnt_clr;
          sel_d   = gnt_sel;
          busy_d  = 1'b1;
          for (int o = 0; o < NPORT; o++) begin
            if (gnt_wr[o]) ptr_d[o] = gnt_sel[o] + 2'd1;
          end
        end
      end
      ISSUE: begin
        state_d = ARB;
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State, pointers and registered strobes; reset abandons any pending transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ARB;
      ptr                  <= '0;
      wr_data              <= '0;
      clear_data_available <= '0;
      select_out           <= '0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_d;
      ptr                  <= ptr_d;
      wr_data              <= wr_d;
      clear_data_available <= clr_d;
      select_out           <= sel_d;
      busy                 <= busy_d;
    end
  end

`ifdef ROUTER_SCHED_STATS_EN
  // Saturating per-input grant counters; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (stats_clr) begin
          grant_cnt[i] <= '0;
        end else if ((state == ISSUE) && clear_data_available[i] &&
                     (grant_cnt[i] != {CNT_W{1'b1}})) begin
          grant_cnt[i] <= grant_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule
